vc_ramp_gen: RTL

- Multi-channel delay-offset ramp generator for the voice-corruptor path.
- Parametrised successor to the fixed three-trigger offset counter.
- Each of NCH trigger lines selects its own down-ramp with a per-channel start value. The selected ramp drives `count`, which downstream delay-line addressing uses as the read offset.
- Adds a sample-rate step enable, four ramp modes (wrap, hold, ping-pong, freeze), and status outputs.

---
 rtl/vc_pkg.sv | 16 +
 rtl/vc_ramp_chan.sv | 90 +++++++++
 rtl/vc_ramp_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Shared constants for the voice-corruptor ramp generator.
package vc_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_WRAP     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_HOLD     = 2'b01;
  localparam logic [MODE_W-1:0] MODE_PINGPONG = 2'b10;
  localparam logic [MODE_W-1:0] MODE_FREEZE   = 2'b11;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/vc_ramp_chan.sv
// One ramp counter: reloads to START whenever its channel is not selected,
// otherwise steps on each strobe according to the ramp mode.
module vc_ramp_chan
  import vc_pkg::*;
#(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] START = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_step,
  input  logic              i_reload,
  input  logic [MODE_W-1:0] i_mode,
  output logic [WIDTH-1:0]  o_cnt,
  output logic              o_at_zero,
  output logic              o_turn
);

  logic [WIDTH-1:0] r_cnt;
  dir_e             r_dir;
  logic [WIDTH-1:0] w_cnt_nxt;
  dir_e             w_dir_nxt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // Next counter / direction and the turn-around pulse for this channel.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    o_turn    = 1'b0;
    if (i_reload) begin
      w_cnt_nxt = START;
      w_dir_nxt = DIR_DOWN;
    end else begin
      // Leaving ping-pong always resumes downward when it is re-entered.
      if (i_mode != MODE_PINGPONG) w_dir_nxt = DIR_DOWN;
      if (i_step) begin
        case (i_mode)
          MODE_WRAP: begin
            if (w_zero) begin
              w_cnt_nxt = START;
              o_turn    = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - WIDTH'(1);
            end
          end
          MODE_HOLD: begin
            if (!w_zero) w_cnt_nxt = r_cnt - WIDTH'(1);
          end
          MODE_PINGPONG: begin
            if (r_dir == DIR_DOWN) begin
              if (!w_zero) begin
                w_cnt_nxt = r_cnt - WIDTH'(1);
              end else if (START != '0) begin
                // A zero start value pins the ramp at 0 with no pulse.
                w_dir_nxt = DIR_UP;
                w_cnt_nxt = WIDTH'(1);
                o_turn    = 1'b1;
              end
            end else begin
              if (r_cnt < START) begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
              end else begin
                w_dir_nxt = DIR_DOWN;
                if (!w_zero) w_cnt_nxt = r_cnt - WIDTH'(1);
              end
            end
          end
          default: ; // freeze: hold value
        endcase
      end
    end
  end

  // Counter and direction state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= START;
      r_dir <= DIR_DOWN;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_at_zero = w_zero;

endmodule

// File: rtl/vc_ramp_gen.sv
// Multi-channel delay-offset ramp generator: lowest set trigger selects a
// channel ramp, whose pre-step value is registered onto count.
module vc_ramp_gen
  import vc_pkg::*;
#(
  parameter int                   WIDTH     = 13,
  parameter int                   NCH       = 4,
  parameter logic [NCH*WIDTH-1:0] START_VEC = {13'd63, 13'd127, 13'd255, 13'd393},
  parameter logic [WIDTH-1:0]     IDLE_VAL  = 13'd393,
  localparam int                  CW        = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              samp_en,
  input  logic [NCH-1:0]    trig,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  count,
  output logic              active,
  output logic [CW-1:0]     ch_idx,
  output logic              wrap_pulse,
  output logic              done
);

  logic                      w_any;
  logic [CW-1:0]             w_sel;
  logic [NCH-1:0]            w_reload;
  logic [NCH-1:0][WIDTH-1:0] w_cnt;
  logic [NCH-1:0]            w_zero;
  logic [NCH-1:0]            w_turn;

  logic [WIDTH-1:0] r_count;
  logic             r_active;
  logic [CW-1:0]    r_ch_idx;
  logic             r_wrap;
  logic             r_done;

  // Priority encoder: lowest set trigger bit wins.
  always_comb begin
    w_any = |trig;
    w_sel = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (trig[k]) w_sel = CW'(k);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_reload[gi] = !(w_any && (w_sel == CW'(gi)));

    vc_ramp_chan #(
      .WIDTH (WIDTH),
      .START (START_VEC[gi*WIDTH +: WIDTH])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_step    (samp_en),
      .i_reload  (w_reload[gi]),
      .i_mode    (mode),
      .o_cnt     (w_cnt[gi]),
      .o_at_zero (w_zero[gi]),
      .o_turn    (w_turn[gi])
    );
  end

  // Output registers: selected channel's pre-step state, or idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= IDLE_VAL;
      r_active <= 1'b0;
      r_ch_idx <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else if (!w_any) begin
      r_count  <= IDLE_VAL;
      r_active <= 1'b0;
      r_ch_idx <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_cnt[w_sel];
      r_active <= 1'b1;
      r_ch_idx <= w_sel;
      r_wrap   <= w_turn[w_sel];
      r_done   <= (mode == MODE_HOLD) && w_zero[w_sel];
    end
  end

  assign count      = r_count;
  assign active     = r_active;
  assign ch_idx     = r_ch_idx;
  assign wrap_pulse = r_wrap;
  assign done       = r_done;

endmodule
